// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and instruction-fetch sequencer.
// Each instruction is fetched from memory over a req/ack handshake. It is then
// presented to decode for one EXEC cycle. In that cycle the decoder's branch
// code, the ALU zero/less flags, the immediate and rs1 resolve the next PC.
// An aligned target updates the PC. A misaligned taken target sets a sticky
// trap flag and parks the unit in TRAP until reset.
// Optional feature: define PC_FETCH_TAKEN_COUNT_EN to add a 32-bit taken_count
// output. It counts the non-trapping taken redirects.
module pc_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  output logic            instr_valid,
  input  logic [2:0]      branch,
  input  logic            zero,
  input  logic            less,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  input  logic            halt,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            taken,
  output logic            misalign
`ifdef PC_FETCH_TAKEN_COUNT_EN
  ,
  output logic [31:0]     taken_count
`endif
);

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_EXEC,
    ST_HALT,
    ST_TRAP
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            misalign_q, misalign_d;

  logic            br_taken;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] next_pc;
  logic            in_exec;
  logic            misalign_hit;

  assign pc_plus4  = pc_q + XLEN'(4);
  assign br_target = pc_q + imm;
  assign jalr_sum  = rs1_data + imm;

  // Decode the branch code into a redirect decision and its target address.
  always_comb begin
    // NOTE: every output of this block is given a default first, so no path leaves one unassigned and no latch is inferred.
    br_taken = 1'b0;
    target   = br_target;
    case (branch)
      3'b001: br_taken = 1'b1;
      3'b010: begin
        br_taken = 1'b1;
        target   = {jalr_sum[XLEN-1:1], 1'b0};
      end
      3'b100: br_taken = zero;
      3'b101: br_taken = !zero;
      3'b110: br_taken = less;
      3'b111: br_taken = !less;
      default: br_taken = 1'b0;  // 000 sequential, 011 reserved
    endcase
  end

  // rst_n gates the request so it drops the instant reset is asserted,
  // without waiting for the state register to update.
  assign in_exec      = (state_q == ST_EXEC);
  assign imem_req     = rst_n && (state_q == ST_FETCH);
  assign imem_addr    = pc_q;
  assign instr_valid  = rst_n && in_exec;
  assign taken        = rst_n && in_exec && br_taken;
  assign next_pc      = taken ? target : pc_plus4;
  assign misalign_hit = taken && (next_pc[1:0] != 2'b00);

  assign pc       = pc_q;
  assign instr    = instr_q;
  assign misalign = misalign_q;

  // Next-state logic: fetch handshake, EXEC resolution, halt wait, trap park.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    misalign_d = misalign_q;
    case (state_q)
      ST_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (misalign_hit) begin
          misalign_d = 1'b1;
          state_d    = ST_TRAP;
        end else begin
          pc_d    = next_pc;
          state_d = halt ? ST_HALT : ST_FETCH;
        end
      end
      ST_HALT: begin
        if (!halt) state_d = ST_FETCH;
      end
      default: state_d = ST_TRAP;  // TRAP holds until reset
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values.
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      misalign_q <= misalign_d;
    end
  end

`ifdef PC_FETCH_TAKEN_COUNT_EN
  logic [31:0] taken_count_q, taken_count_d;

  assign taken_count_d = (taken && !misalign_hit) ? taken_count_q + 32'd1 : taken_count_q;
  assign taken_count   = taken_count_q;

  // Count the taken redirects that retire without trapping. The count wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) taken_count_q <= '0;
    else        taken_count_q <= taken_count_d;
  end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit. A table of instruction records is
// chained so that each record starts at the PC the previous one produced.
// Hand-written sequences cover halt, the stray ack, the misaligned trap and
// reset taken mid-fetch.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [2:0]  branch;
  logic        zero, less;
  logic [31:0] imm, rs1_data;
  logic        halt;
  logic [31:0] pc, pc_plus4;
  logic        taken, misalign;
`ifdef PC_FETCH_TAKEN_COUNT_EN
  logic [31:0] taken_count;
`endif

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  pc_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_valid(instr_valid),
    .branch     (branch),
    .zero       (zero),
    .less       (less),
    .imm        (imm),
    .rs1_data   (rs1_data),
    .halt       (halt),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .taken      (taken),
    .misalign   (misalign)
`ifdef PC_FETCH_TAKEN_COUNT_EN
    ,
    .taken_count(taken_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] addr;
    int          delay;
    logic [31:0] rdata;
    logic [2:0]  br;
    logic        z;
    logic        l;
    logic [31:0] im;
    logic [31:0] rs1;
    logic        hlt;
    logic        exp_taken;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(input logic [31:0] addr, input int delay, input logic [31:0] rdata,
                              input logic [2:0] br, input logic z, input logic l,
                              input logic [31:0] im, input logic [31:0] rs1, input logic hlt,
                              input logic exp_taken, input logic [31:0] exp_pc);
    vec_t v;
    v.addr = addr; v.delay = delay; v.rdata = rdata; v.br = br; v.z = z; v.l = l;
    v.im = im; v.rs1 = rs1; v.hlt = hlt; v.exp_taken = exp_taken; v.exp_pc = exp_pc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Fetch one instruction (ack after v.delay idle cycles), resolve it in EXEC, check the new PC.
  task automatic run_instr(input vec_t v, input int idx);
    for (int i = 0; i < v.delay; i++) begin
      check($sformatf("v%0d req_wait", idx), 32'(imem_req), 32'd1);
      check($sformatf("v%0d addr_wait", idx), imem_addr, v.addr);
      step();
    end
    check($sformatf("v%0d req", idx), 32'(imem_req), 32'd1);
    check($sformatf("v%0d addr", idx), imem_addr, v.addr);
    check($sformatf("v%0d valid_fetch", idx), 32'(instr_valid), 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = v.rdata;
    branch     = v.br;
    zero       = v.z;
    less       = v.l;
    imm        = v.im;
    rs1_data   = v.rs1;
    halt       = v.hlt;
    step();
    imem_ack = 1'b0;
    check($sformatf("v%0d valid_exec", idx), 32'(instr_valid), 32'd1);
    check($sformatf("v%0d instr", idx), instr, v.rdata);
    check($sformatf("v%0d req_exec", idx), 32'(imem_req), 32'd0);
    check($sformatf("v%0d taken", idx), 32'(taken), 32'(v.exp_taken));
    step();
    check($sformatf("v%0d pc", idx), pc, v.exp_pc);
    check($sformatf("v%0d valid_after", idx), 32'(instr_valid), 32'd0);
  endtask

  initial begin
    //           addr          dly rdata          br      z     l     imm            rs1            hlt   tkn   next pc
    vecs[0]  = mk(32'h0000_0000, 2, 32'h0000_0013, 3'b000, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0004);
    vecs[1]  = mk(32'h0000_0004, 0, 32'h0FC0_006F, 3'b001, 1'b0, 1'b0, 32'h0000_00FC, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0100);
    vecs[2]  = mk(32'h0000_0100, 1, 32'hFE00_08E3, 3'b100, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_00F0);
    vecs[3]  = mk(32'h0000_00F0, 0, 32'h0000_8067, 3'b010, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0100, 1'b0, 1'b1, 32'h0000_0100);
    vecs[4]  = mk(32'h0000_0100, 0, 32'hFE00_08E3, 3'b100, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0104);
    vecs[5]  = mk(32'h0000_0104, 0, 32'h0000_1863, 3'b101, 1'b0, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0114);
    vecs[6]  = mk(32'h0000_0114, 0, 32'h0000_1863, 3'b101, 1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0118);
    vecs[7]  = mk(32'h0000_0118, 0, 32'h0000_4463, 3'b110, 1'b0, 1'b1, 32'h0000_0008, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0120);
    vecs[8]  = mk(32'h0000_0120, 0, 32'h0000_5463, 3'b111, 1'b0, 1'b1, 32'h0000_0008, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0124);
    vecs[9]  = mk(32'h0000_0124, 0, 32'hFE00_5EE3, 3'b111, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0120);
    vecs[10] = mk(32'h0000_0120, 0, 32'h0000_0033, 3'b011, 1'b1, 1'b1, 32'h0000_0040, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0124);
    vecs[11] = mk(32'h0000_0124, 0, 32'h0090_8067, 3'b010, 1'b0, 1'b0, 32'h0000_0009, 32'h0000_1000, 1'b0, 1'b1, 32'h0000_1008);
    vecs[12] = mk(32'h0000_1008, 0, 32'h0000_8067, 3'b010, 1'b0, 1'b0, 32'h0000_0000, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'hFFFF_FFFC);
    vecs[13] = mk(32'hFFFF_FFFC, 0, 32'h0000_0013, 3'b000, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000);
    vecs[14] = mk(32'h0000_0000, 0, 32'h0200_006F, 3'b001, 1'b0, 1'b0, 32'h0000_0020, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0020);

    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; branch = '0; zero = 1'b0;
    less = 1'b0; imm = '0; rs1_data = '0; halt = 1'b0;

    // Outputs held in reset.
    repeat (2) step();
    check("rst req", 32'(imem_req), 32'd0);
    check("rst valid", 32'(instr_valid), 32'd0);
    check("rst taken", 32'(taken), 32'd0);
    check("rst pc", pc, 32'h0);
    check("rst pc_plus4", pc_plus4, 32'h4);
    check("rst instr", instr, 32'h0);
    check("rst misalign", 32'(misalign), 32'd0);
`ifdef PC_FETCH_TAKEN_COUNT_EN
    check("rst count", taken_count, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Chained table of instructions.
    for (int i = 0; i < 15; i++) begin
      run_instr(vecs[i], i);
      if (vecs[i].exp_taken) exp_cnt++;
    end
    check("pc_plus4 at 0x20", pc_plus4, 32'h24);
`ifdef PC_FETCH_TAKEN_COUNT_EN
    check("count after table", taken_count, 32'(exp_cnt));
`endif

    // Halt during EXEC at 0x20; hold halt, pulse a stray ack, then release.
    run_instr(mk(32'h20, 0, 32'h0000_0013, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h24), 100);
    for (int i = 0; i < 3; i++) begin
      check("halt req", 32'(imem_req), 32'd0);
      step();
    end
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    check("halt stray ack instr", instr, 32'h0000_0013);
    check("halt stray ack pc", pc, 32'h24);
    check("halt stray ack valid", 32'(instr_valid), 32'd0);
    halt = 1'b0;
    check("halt drop req same cycle", 32'(imem_req), 32'd0);
    step();
    check("resume req", 32'(imem_req), 32'd1);
    check("resume addr", imem_addr, 32'h24);

    // jalr to 0x2001+2 = 0x2003 -> 0x2002 (bit1 set) traps, pc holds.
    run_instr(mk(32'h24, 0, 32'h0020_8067, 3'b010, 1'b0, 1'b0, 32'h2, 32'h2001, 1'b0, 1'b1, 32'h24), 101);
    check("trap misalign", 32'(misalign), 32'd1);
    for (int i = 0; i < 4; i++) begin
      imem_ack = (i % 2 == 0);
      imem_rdata = 32'hBAD0_BAD0;
      step();
      check("trap req", 32'(imem_req), 32'd0);
      check("trap valid", 32'(instr_valid), 32'd0);
      check("trap pc", pc, 32'h24);
      check("trap misalign held", 32'(misalign), 32'd1);
    end
    imem_ack = 1'b0;
    check("trap instr", instr, 32'h0020_8067);
`ifdef PC_FETCH_TAKEN_COUNT_EN
    check("count after trap", taken_count, 32'(exp_cnt));
`endif

    // Reset clears the trap; then reset again mid-fetch drops the request at once.
    rst_n = 1'b0;
    #1;
    check("rst2 misalign", 32'(misalign), 32'd0);
    check("rst2 pc", pc, 32'h0);
    check("rst2 instr", instr, 32'h0);
`ifdef PC_FETCH_TAKEN_COUNT_EN
    check("rst2 count", taken_count, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("refetch req", 32'(imem_req), 32'd1);
    check("refetch addr", imem_addr, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midfetch rst req", 32'(imem_req), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_instr(mk(32'h0, 1, 32'h0000_0013, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h4), 102);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
